// File: rtl/adder_fu_pkg.sv
// Shared types and constants for the adder FU sequencer.
package adder_fu_pkg;

    // Adder lane modes; encoding 2'b10 is reserved and rejected.
    typedef enum logic [1:0] {
        MODE_4X16 = 2'd0,
        MODE_2X32 = 2'd1,
        MODE_1X64 = 2'd3
    } adder_mode_e;

    localparam logic [1:0] MODE_INVALID = 2'b10;

    // Config word fields.
    localparam int unsigned CFG_W        = 16;
    localparam int unsigned CFG_MODE_LSB = 0;
    localparam int unsigned CFG_MODE_W   = 2;
    localparam int unsigned CFG_DEST_LSB = 2;
    localparam int unsigned CFG_DEST_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_OP,
        RUN,
        RESULT
    } seq_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MODE    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic mode_valid(input logic [1:0] mode);
        return mode inside {MODE_4X16, MODE_2X32, MODE_1X64};
    endfunction

endpackage

// File: rtl/adder_fu_seq_if.sv
// Operand, FU and result-routing signals between the sequencer and the tile.
interface adder_fu_seq_if #(
    parameter int unsigned aw = 3
) ();
    import adder_fu_pkg::*;

    logic                  op_valid;
    logic                  op_ready;
    logic                  fu_on_off;
    logic [CFG_W-1:0]      fu_config;
    logic                  fu_ack;
    logic [CFG_DEST_W-1:0] fu_dest_info;
    logic                  res_valid;
    logic                  res_ready;
    logic [CFG_DEST_W-1:0] res_dest;
    logic [aw-1:0]         res_index;

    modport master (
        input  op_valid,
        output op_ready,
        output fu_on_off,
        output fu_config,
        input  fu_ack,
        input  fu_dest_info,
        output res_valid,
        input  res_ready,
        output res_dest,
        output res_index
    );

    modport slave (
        output op_valid,
        input  op_ready,
        input  fu_on_off,
        input  fu_config,
        output fu_ack,
        output fu_dest_info,
        input  res_valid,
        output res_ready,
        input  res_dest,
        input  res_index
    );

endinterface

// File: rtl/cfg_prog_mem.sv
// Program store: one write port, one asynchronous read port, no reset.
module cfg_prog_mem
    import adder_fu_pkg::*;
#(
    parameter int unsigned depth = 8,
    parameter int unsigned aw    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [CFG_W-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [CFG_W-1:0] rdata
);

    logic [CFG_W-1:0] mem [depth];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adder_fu_seq.sv
// Sequencer stepping the adder FU through a stored program of config words.
module adder_fu_seq
    import adder_fu_pkg::*;
#(
    parameter  int unsigned prog_depth     = 8,
    parameter  int unsigned timeout_cycles = 15,
    localparam int unsigned aw             = $clog2(prog_depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [aw-1:0]    prog_addr,
    input  logic [CFG_W-1:0] prog_data,
    input  logic [aw:0]      prog_len,
    input  logic             start,
    input  logic             loop_en,
    input  logic             abort,
    adder_fu_seq_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int unsigned   CntW     = $clog2(timeout_cycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(timeout_cycles - 1);
    localparam logic [aw:0]   DepthLen = (aw + 1)'(prog_depth);

    seq_state_e            state_q;
    logic [aw-1:0]         pc_q;
    logic [aw:0]           len_q;
    logic                  loop_q;
    logic [CFG_W-1:0]      cfg_q;
    logic [CFG_W-1:0]      fu_config_q;
    logic [CntW-1:0]       cnt_q;
    logic [CFG_DEST_W-1:0] res_dest_q;
    logic [aw-1:0]         res_index_q;
    logic                  done_q;
    logic                  err_q;
    logic [1:0]            err_code_q;

    logic [CFG_W-1:0]      rd_data;
    logic [aw:0]           pc_inc;
    seq_state_e            adv_state;
    logic [aw-1:0]         adv_pc;
    logic                  adv_done;

    cfg_prog_mem #(
        .depth (prog_depth),
        .aw    (aw)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    // Where the sequencer goes after finishing (or skipping) the current entry.
    always_comb begin
        pc_inc    = {1'b0, pc_q} + 1'b1;
        adv_state = FETCH;
        adv_pc    = pc_q + 1'b1;
        adv_done  = 1'b0;
        if (pc_inc >= len_q) begin
            adv_pc = '0;
            if (!loop_q) begin
                adv_state = IDLE;
                adv_done  = 1'b1;
            end
        end
    end

    // Main sequencer FSM; abort overrides every other input but keeps err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            cfg_q       <= '0;
            fu_config_q <= '0;
            cnt_q       <= '0;
            res_dest_q  <= '0;
            res_index_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (prog_len == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                len_q      <= (prog_len > DepthLen) ? DepthLen : prog_len;
                                loop_q     <= loop_en;
                                pc_q       <= '0;
                                err_q      <= 1'b0;
                                err_code_q <= ERR_NONE;
                                state_q    <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        cfg_q <= rd_data;
                        if (!mode_valid(rd_data[CFG_MODE_LSB +: CFG_MODE_W])) begin
                            err_q <= 1'b1;
                            if (err_code_q == ERR_NONE) err_code_q <= ERR_MODE;
                            state_q <= adv_state;
                            pc_q    <= adv_pc;
                            done_q  <= adv_done;
                        end else begin
                            state_q <= WAIT_OP;
                        end
                    end
                    WAIT_OP: begin
                        if (bus.op_valid) begin
                            fu_config_q <= cfg_q;
                            cnt_q       <= '0;
                            state_q     <= RUN;
                        end
                    end
                    RUN: begin
                        cnt_q <= cnt_q + 1'b1;
                        // An ack on the last allowed cycle still counts as success.
                        if (bus.fu_ack) begin
                            res_dest_q  <= bus.fu_dest_info;
                            res_index_q <= pc_q;
                            state_q     <= RESULT;
                        end else if (cnt_q == CntLast) begin
                            err_q <= 1'b1;
                            if (err_code_q == ERR_NONE) err_code_q <= ERR_TIMEOUT;
                            state_q <= adv_state;
                            pc_q    <= adv_pc;
                            done_q  <= adv_done;
                        end
                    end
                    RESULT: begin
                        if (bus.res_ready) begin
                            state_q <= adv_state;
                            pc_q    <= adv_pc;
                            done_q  <= adv_done;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.op_ready  = (state_q == WAIT_OP);
    assign bus.fu_on_off = (state_q == RUN);
    assign bus.fu_config = fu_config_q;
    assign bus.res_valid = (state_q == RESULT);
    assign bus.res_dest  = res_dest_q;
    assign bus.res_index = res_index_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_adder_fu_seq.sv
// Randomised bench for adder_fu_seq against a per-program outcome model.
module tb_adder_fu_seq;
    import adder_fu_pkg::*;

    localparam int unsigned Depth = 8;
    localparam int unsigned Tmo   = 15;
    localparam int unsigned AW    = 3;

    typedef struct packed {
        logic [3:0]    dest;
        logic [AW-1:0] idx;
    } res_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          loop_en;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    adder_fu_seq_if #(.aw(AW)) bus ();

    adder_fu_seq #(
        .prog_depth     (Depth),
        .timeout_cycles (Tmo)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .loop_en   (loop_en),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [15:0] mem_m [Depth];
    int          dly_a [Depth];  // per valid visit: ack after N on-cycles, 0 = never
    logic [3:0]  msk_a [Depth];  // per valid visit: FU dest = config dest ^ mask
    int          delay_q [$];
    logic [3:0]  mask_q [$];
    res_t        exp_q [$];
    int          exp_on;
    logic        exp_err;
    logic [1:0]  exp_code;

    // FU / downstream model state.
    int          on_cnt;
    int          on_total;
    int          cur_delay;
    logic [3:0]  cur_mask;
    int          hold_left;
    int          done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic prog_write(input int a, input logic [15:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        mem_m[a]  = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Expected outcome of a one-shot program run, entry by entry.
    task automatic build_model(input int len);
        int n;
        int v;
        res_t r;
        n = (len > int'(Depth)) ? int'(Depth) : len;
        v = 0;
        exp_q.delete();
        delay_q.delete();
        mask_q.delete();
        exp_on   = 0;
        exp_err  = 1'b0;
        exp_code = 2'b00;
        for (int i = 0; i < n; i++) begin
            if (mem_m[i][1:0] == 2'b10) begin
                if (!exp_err) exp_code = 2'b01;
                exp_err = 1'b1;
            end else begin
                delay_q.push_back(dly_a[v]);
                mask_q.push_back(msk_a[v]);
                if (dly_a[v] >= 1 && dly_a[v] <= int'(Tmo)) begin
                    r.dest = mem_m[i][5:2] ^ msk_a[v];
                    r.idx  = AW'(i);
                    exp_q.push_back(r);
                    exp_on += dly_a[v];
                end else begin
                    exp_on += int'(Tmo);
                    if (!exp_err) exp_code = 2'b10;
                    exp_err = 1'b1;
                end
                v++;
            end
        end
    endtask

    // One cycle: FU model, operand source, result sink, done counting.
    task automatic step();
        logic r;
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        abort   = 1'b0;
        if (bus.fu_on_off) begin
            on_cnt++;
            on_total++;
            if (on_cnt == 1) begin
                cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                cur_mask  = (mask_q.size() > 0) ? mask_q.pop_front() : 4'h0;
            end
        end else begin
            on_cnt = 0;
        end
        bus.fu_ack       = bus.fu_on_off && (on_cnt == cur_delay);
        bus.fu_dest_info = bus.fu_config[CFG_DEST_LSB +: CFG_DEST_W] ^ cur_mask;
        bus.op_valid     = 1'($urandom_range(0, 1));
        r = 1'b0;
        if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("res_unexpected", bus.res_valid, 0);
            end else begin
                check_eq("res_dest", bus.res_dest, exp_q[0].dest);
                check_eq("res_index", bus.res_index, exp_q[0].idx);
            end
            if (hold_left > 0) hold_left--;
            else r = ($urandom_range(0, 2) != 0);
            if (r && exp_q.size() > 0) exp_q.delete(0);
        end
        bus.res_ready = r;
        if (done) done_cnt++;
    endtask

    task automatic run_prog(input int len, input int hold, input bit poke,
                            input bit wr_start, input logic [15:0] wr_word);
        bit fin;
        bit poked;
        fin   = 1'b0;
        poked = 1'b0;
        if (wr_start) mem_m[0] = wr_word;
        build_model(len);
        hold_left = hold;
        done_cnt  = 0;
        on_total  = 0;
        on_cnt    = 0;
        @(negedge clk);
        start    = 1'b1;
        prog_len = (AW + 1)'(len);
        loop_en  = 1'b0;
        if (wr_start) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = wr_word;
        end
        if (len == 0) begin
            step();
            check_eq("len0_done", done_cnt, 1);
            check_eq("len0_busy", busy, 0);
            return;
        end
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            step();
            if (!busy) begin
                fin = 1'b1;
            end else if (poke && !poked && bus.fu_on_off) begin
                // Start and program write while busy must both be ignored.
                start     = 1'b1;
                prog_len  = 1;
                prog_we   = 1'b1;
                prog_addr = 1;
                prog_data = 16'h0002;
                poked     = 1'b1;
            end
        end
        check_eq("run_finished", fin, 1);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("results_left", exp_q.size(), 0);
        check_eq("on_cycles", on_total, exp_on);
        check_eq("err", err, exp_err);
        check_eq("err_code", err_code, exp_code);
    endtask

    task automatic loop_abort();
        res_t r;
        prog_write(0, 16'h0019);  // mode 1, dest 6
        exp_q.delete();
        delay_q = '{2, 4, 1};
        mask_q  = '{4'h0, 4'h0, 4'h0};
        r.dest = 4'd6;
        r.idx  = '0;
        for (int i = 0; i < 3; i++) exp_q.push_back(r);
        hold_left = 0;
        done_cnt  = 0;
        on_cnt    = 0;
        @(negedge clk);
        start    = 1'b1;
        prog_len = 1;
        loop_en  = 1'b1;
        for (int cyc = 0; cyc < 500 && exp_q.size() > 0; cyc++) step();
        check_eq("loop_results_left", exp_q.size(), 0);
        check_eq("loop_no_done", done_cnt, 0);
        check_eq("loop_busy", busy, 1);
        abort = 1'b1;
        step();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_on_off", bus.fu_on_off, 0);
        check_eq("abort_res_valid", bus.res_valid, 0);
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_err_kept", err, 0);
        loop_en = 1'b0;
        step();
        check_eq("abort_still_no_done", done_cnt, 0);
    endtask

    task automatic reset_mid_run();
        bit seen;
        seen = 1'b0;
        prog_write(0, 16'h0015);  // mode 1, dest 5
        dly_a[0] = 0;
        build_model(1);
        on_cnt = 0;
        @(negedge clk);
        start    = 1'b1;
        prog_len = 1;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            step();
            if (bus.fu_on_off) seen = 1'b1;
        end
        check_eq("rst_reached_run", seen, 1);
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        check_eq("arst_on_off", bus.fu_on_off, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_fu_config", bus.fu_config, 0);
        check_eq("arst_res_valid", bus.res_valid, 0);
        check_eq("arst_op_ready", bus.op_ready, 0);
        check_eq("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        prog_we          = 1'b0;
        prog_addr        = '0;
        prog_data        = '0;
        prog_len         = '0;
        start            = 1'b0;
        loop_en          = 1'b0;
        abort            = 1'b0;
        bus.op_valid     = 1'b0;
        bus.fu_ack       = 1'b0;
        bus.fu_dest_info = '0;
        bus.res_ready    = 1'b0;
        cur_delay        = 0;
        cur_mask         = '0;
        for (int v = 0; v < int'(Depth); v++) msk_a[v] = 4'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_op_ready", bus.op_ready, 0);
        check_eq("rst_on_off", bus.fu_on_off, 0);
        check_eq("rst_fu_config", bus.fu_config, 0);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_res_dest", bus.res_dest, 0);
        check_eq("rst_res_index", bus.res_index, 0);
        reset = 1'b0;

        // Two plain entries, ack three cycles into each.
        prog_write(0, 16'h0000);
        prog_write(1, 16'h0001);
        dly_a[0] = 3;
        dly_a[1] = 3;
        run_prog(2, 0, 1'b0, 1'b0, 16'h0);

        // Result held under backpressure.
        prog_write(0, 16'h0034);
        dly_a[0] = 3;
        run_prog(1, 5, 1'b0, 1'b0, 16'h0);

        // Invalid mode skipped, following entry still runs.
        prog_write(0, 16'h0002);
        prog_write(1, 16'h0003);
        dly_a[0] = 2;
        run_prog(2, 0, 1'b0, 1'b0, 16'h0);

        // FU never acks: timeout.
        prog_write(0, 16'h0001);
        dly_a[0] = 0;
        run_prog(1, 0, 1'b0, 1'b0, 16'h0);

        // Ack on the final allowed cycle beats the timeout.
        dly_a[0] = Tmo;
        run_prog(1, 0, 1'b0, 1'b0, 16'h0);

        loop_abort();
        reset_mid_run();

        // Start and write while busy ignored; write alongside start lands.
        prog_write(0, 16'h0008);
        prog_write(1, 16'h0015);
        dly_a[0] = 4;
        dly_a[1] = 2;
        run_prog(2, 0, 1'b1, 1'b1, 16'h0027);

        for (int t = 0; t < 40; t++) begin
            for (int a = 0; a < int'(Depth); a++) prog_write(a, 16'($urandom));
            for (int v = 0; v < int'(Depth); v++) begin
                dly_a[v] = $urandom_range(0, 17);
                msk_a[v] = 4'($urandom);
            end
            run_prog($urandom_range(0, 15), $urandom_range(0, 3), 1'b0,
                     1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_fu_seq.md
Name: adder_fu_seq

Overview:
- Sequencer in front of the tile's configurable adder functional unit.
- Holds a small program of 16-bit FU configuration words and steps through them in order.
- For each word: waits for operands from the tile interconnect, runs the FU until it acks or times out, then presents routing info downstream through a valid/ready handshake.
- Rejects invalid adder modes and optionally loops the program.

Parameters:
- prog_depth, 8: number of config-word entries; power of 2, at least 2.
- timeout_cycles, 15: maximum cycles in RUN without fu_ack before a timeout error.
- aw, $clog2(prog_depth): program address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- prog_we  in  1  program write strobe; ignored while busy=1.
- prog_addr  in  aw  program write address.
- prog_data  in  16  config word; [1:0] adder mode, [5:2] dest, [15:6] reserved (passed through).
- prog_len  in  aw+1  number of entries to run, sampled on start.
- start  in  1  single-cycle start pulse; ignored while busy=1.
- loop_en  in  1  when 1, wrap pc to 0 after the last entry; sampled on start.
- abort  in  1  synchronous abort to IDLE; has priority over every other input.
- op_valid  in  1  operands present on the FU inputs.
- op_ready  out  1  sequencer accepts operands.
- fu_on_off  out  1  FU enable.
- fu_config  out  16  config word driven to the FU.
- fu_ack  in  1  FU completion.
- fu_dest_info  in  4  FU dest output.
- res_valid  out  1  result routing info valid.
- res_ready  in  1  downstream accepts.
- res_dest  out  4  captured fu_dest_info.
- res_index  out  aw  pc of the entry that produced the result.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at program end.
- err  out  1  sticky error flag; cleared on an accepted start.
- err_code  out  2  00 none, 01 invalid mode, 10 timeout; first error wins.

Behaviour:
- Reset values: state IDLE, pc=0, every output 0, fu_config=0, program memory contents undefined (not reset).
- Program writes: mem[prog_addr] <= prog_data on clock when prog_we=1 and busy=0. A write issued in the same cycle as an accepted start still lands.
- IDLE:
  - start with prog_len==0: done pulses next cycle, stay IDLE.
  - start with prog_len>prog_depth: clamp prog_len to prog_depth.
  - start otherwise: latch prog_len and loop_en, pc=0, clear err/err_code, go to FETCH.
- FETCH (1 cycle): cfg <= mem[pc].
  - If mem[pc][1:0]==2'b10: set err (code 01 if none yet), then ADVANCE.
  - Else: go to WAIT_OP.
- WAIT_OP: op_ready=1. On op_valid, go to RUN. fu_on_off=1 and fu_config=cfg from the next cycle.
- RUN: fu_on_off=1, cycle counter increments each cycle.
  - fu_ack: capture res_dest=fu_dest_info and res_index=pc, go to RESULT.
  - No ack and counter==timeout_cycles-1: set err (code 10 if none yet), then ADVANCE.
  - fu_on_off drops the cycle after leaving RUN.
- RESULT: res_valid=1. res_dest and res_index are held stable until res_ready, then ADVANCE.
- ADVANCE (a transition, not a state):
  - If pc+1 < len: pc++, go to FETCH.
  - Else if loop_en: pc=0, go to FETCH.
  - Else: go to IDLE with a done pulse in the first IDLE cycle.
- Latency: start accepted at cycle 0 -> FETCH at cycle 1 -> op_ready at cycle 2. op_valid accepted at cycle N -> fu_on_off=1 at N+1.
- fu_config holds its last value outside RUN; only fu_on_off gates the FU.
- abort in any state: next cycle state=IDLE, fu_on_off=0, res_valid=0, no done pulse, err preserved.
- Simultaneous fu_ack and timeout in the same cycle: the ack wins.
- Asynchronous reset mid-RUN: fu_on_off drops immediately, with no result or done.

Decomposition:
- Package adder_fu_pkg holds:
  - the adder mode enum: MODE_4X16=0, MODE_2X32=1, MODE_1X64=3, with 2 invalid;
  - config field bit positions (mode [1:0], dest [5:2]);
  - the sequencer state enum {IDLE, FETCH, WAIT_OP, RUN, RESULT};
  - the err_code constants.
- Sub-module cfg_prog_mem: a prog_depth x 16 register file with one write port and one asynchronous read port.

Test Plan:
- Load mem[0]=0x0000, mem[1]=0x0001; prog_len=2; start; op_valid=1; FU model acks 3 cycles after on_off -> two results: (dest 0, index 0) then (dest 0, index 1); done pulses; err=0.
- Load mem[0]=0x0034 (mode 0, dest 13); start; ack; hold res_ready=0 for 5 cycles -> res_valid and res_dest=13 stable all 5 cycles; advances only after res_ready.
- Load mem[0]=0x0002, mem[1]=0x0003; prog_len=2 -> entry 0 never raises fu_on_off; err=1, err_code=01; entry 1 completes; done pulses.
- FU never acks, timeout_cycles=15 -> fu_on_off high exactly 15 cycles; err_code=10; done pulses.
- prog_len=1, loop_en=1, three acks -> res_index=0 three times with no done; abort -> IDLE next cycle, fu_on_off=0, no done.
- Assert reset asynchronously mid-RUN -> all outputs 0 before the next clock edge; start while busy and prog_we while busy are both ignored.
